csr_timer_unit: RTL

Parametrised timer and interrupt-source block for the CPU's CSR file. It holds the TID, TCFG, TVAL and TICLR CSRs, a 64-bit stable counter, and synchronisers for the hardware and IPI interrupt lines. It supplies ESTAT.IS[12:2] to the main CSR module, which keeps IS[1:0], ECFG masking and has_int generation. The timer width is configurable, and the block adds the stable counter and interrupt synchronisation.

---
 rtl/csr_pkg.sv | 33 +++
 rtl/int_sync.sv | 33 +++
 rtl/csr_timer_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : csr_pkg                                                      |
// | Description : Shared CSR addresses, TCFG/TICLR field positions, IS indices |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package csr_pkg;

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TCFG_INITVAL  = 2;
  localparam int TICLR_CLR     = 0;

  localparam int IS_HWI_LO = 2;
  localparam int IS_HWI_HI = 9;
  localparam int IS_TI     = 11;
  localparam int IS_IPI    = 12;

  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] mask,
                                               input logic [31:0] wdata);
    return (mask & wdata) | (~mask & old_val);
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_sync.sv
// +----------------------------------------------------------------------------+
// | Module      : int_sync                                                     |
// | Description : Multi-bit level synchroniser, STAGES flops deep              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module int_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/csr_timer_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : csr_timer_unit                                               |
// | Description : TID/TCFG/TVAL/TICLR CSRs, stable counter, interrupt syncs    |
// |               Optional macro TIMER_PRESCALE_EN adds a tick prescaler.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module csr_timer_unit
  import csr_pkg::*;
#(
  parameter int          TIMER_W         = 32,
  parameter logic [31:0] COREID          = 32'h0,
  parameter int          HWI_SYNC_STAGES = 2
`ifdef TIMER_PRESCALE_EN
  ,
  parameter int          PRESCALE        = 1
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic        csr_hit,
  output logic [31:0] csr_rvalue,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [10:0] estat_is_hi,
  output logic        timer_int,
  output logic [63:0] stable_cnt
);

  logic               en_q, en_d;
  logic               periodic_q, periodic_d;
  logic [TIMER_W-3:0] initval_q, initval_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               timer_int_q, timer_int_d;
  logic [31:0]        tid_q, tid_d;
  logic [63:0]        stable_q, stable_d;

  logic               tcfg_we, tid_we, ticlr_clr, tick;
  logic [TIMER_W-1:0] tcfg_cur, tcfg_next;
  logic [7:0]         hwi_sync;
  logic               ipi_sync;

  assign tcfg_we   = csr_we && (csr_num == CSR_TCFG);
  assign tid_we    = csr_we && (csr_num == CSR_TID);
  assign ticlr_clr = csr_we && (csr_num == CSR_TICLR)
                     && csr_wmask[TICLR_CLR] && csr_wvalue[TICLR_CLR];

  assign tcfg_cur  = {initval_q, periodic_q, en_q};
  // Bits above TIMER_W never reach the register, so only the low slice is merged.
  assign tcfg_next = (csr_wmask[TIMER_W-1:0] & csr_wvalue[TIMER_W-1:0])
                   | (~csr_wmask[TIMER_W-1:0] & tcfg_cur);

`ifdef TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ps_q <= '0;
    end else if (tcfg_we) begin
      ps_q <= '0;
    end else if (en_q) begin
      ps_q <= (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
    end
  end

  assign tick = (ps_q == PS_LAST);
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    en_d        = en_q;
    periodic_d  = periodic_q;
    initval_d   = initval_q;
    cnt_d       = cnt_q;
    tid_d       = tid_q;
    stable_d    = stable_q + 64'd1;

    if (tcfg_we) begin
      en_d       = tcfg_next[TCFG_EN];
      periodic_d = tcfg_next[TCFG_PERIODIC];
      initval_d  = tcfg_next[TIMER_W-1:TCFG_INITVAL];
      if (tcfg_next[TCFG_EN]) cnt_d = {tcfg_next[TIMER_W-1:TCFG_INITVAL], 2'b00};
    end else if (en_q && (cnt_q != '1) && tick) begin
      // A one-shot timer falls through 0 to all-ones, which parks it.
      if ((cnt_q == '0) && periodic_q) cnt_d = {initval_q, 2'b00};
      else                             cnt_d = cnt_q - TIMER_W'(1);
    end

    if (en_q && (cnt_q == '0)) timer_int_d = 1'b1;
    else if (ticlr_clr)        timer_int_d = 1'b0;
    else                       timer_int_d = timer_int_q;

    if (tid_we) tid_d = masked_write(tid_q, csr_wmask, csr_wvalue);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q        <= 1'b0;
      periodic_q  <= 1'b0;
      initval_q   <= '0;
      cnt_q       <= '1;
      timer_int_q <= 1'b0;
      tid_q       <= COREID;
      stable_q    <= 64'd0;
    end else begin
      en_q        <= en_d;
      periodic_q  <= periodic_d;
      initval_q   <= initval_d;
      cnt_q       <= cnt_d;
      timer_int_q <= timer_int_d;
      tid_q       <= tid_d;
      stable_q    <= stable_d;
    end
  end

  always_comb begin
    csr_hit    = 1'b0;
    csr_rvalue = '0;
    case (csr_num)
      CSR_TID: begin
        csr_hit    = 1'b1;
        csr_rvalue = tid_q;
      end
      CSR_TCFG: begin
        csr_hit                   = 1'b1;
        csr_rvalue[TIMER_W-1:0]   = tcfg_cur;
      end
      CSR_TVAL: begin
        csr_hit                   = 1'b1;
        csr_rvalue[TIMER_W-1:0]   = cnt_q;
      end
      CSR_TICLR: csr_hit = 1'b1;
      default: ;
    endcase
  end

  int_sync #(
    .WIDTH  (9),
    .STAGES (HWI_SYNC_STAGES)
  ) u_int_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    ({ipi_int_in, hw_int_in}),
    .q_o    ({ipi_sync, hwi_sync})
  );

  always_comb begin
    estat_is_hi                                   = '0;
    estat_is_hi[IS_HWI_HI-2:IS_HWI_LO-2]          = hwi_sync;
    estat_is_hi[IS_TI-2]                          = timer_int_q;
    estat_is_hi[IS_IPI-2]                         = ipi_sync;
  end

  assign timer_int  = timer_int_q;
  assign stable_cnt = stable_q;

endmodule

`default_nettype wire
